// File: rtl/ram_master_pkg.sv
// ---------------------------------------------------------------------------
// ram_master_pkg
// Shared types and constants for the ram_master request/response front end.
//   ram_master_state_t : sequencing states of the RAM front end
//   RAM_ADDR_W         : width of word addresses presented to the RAM
//   RAM_DATA_W         : width of a RAM data word
//   RAM_DEPTH_DEFAULT  : default number of words in the attached RAM
//   addr_in_range()    : true when a word index lies inside the RAM
// ---------------------------------------------------------------------------
package ram_master_pkg;

    localparam int RAM_ADDR_W        = 32;
    localparam int RAM_DATA_W        = 32;
    localparam int RAM_DEPTH_DEFAULT = 328;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } ram_master_state_t;

    // Word index compare against the RAM depth; depth is widened to the
    // address width so the compare is unsigned over the full request address.
    function automatic logic addr_in_range(
        input logic [RAM_ADDR_W-1:0] addr,
        input int unsigned           depth
    );
        return addr < RAM_ADDR_W'(depth);
    endfunction

endpackage : ram_master_pkg

// File: rtl/ram_master_if.sv
// ---------------------------------------------------------------------------
// ram_master_if
// Request/response channel between a load/store unit and ram_master.
//   req_valid / req_ready : request handshake
//   req_we                : 1 = store, 0 = load
//   req_addr              : word index (not a byte address)
//   req_wdata             : store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load data, 0 for stores and rejected requests
//   rsp_err               : request was rejected (address out of range)
// Modports:
//   master : the requester (load/store unit, testbench)
//   slave  : ram_master itself
// ---------------------------------------------------------------------------
interface ram_master_if;
    import ram_master_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [RAM_ADDR_W-1:0] req_addr;
    logic [RAM_DATA_W-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [RAM_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

endinterface : ram_master_if

// File: rtl/ram_master.sv
// ---------------------------------------------------------------------------
// ram_master
// Front end for the single-port synchronous data RAM (RamD). Accepts one
// word-addressed load or store at a time, drives the RAM pins with the right
// write strobe and read latency, and returns exactly one response per request.
//
// Parameters:
//   DEPTH      : number of 32-bit words in the attached RAM
//   RD_LATENCY : clocks from RAM address capture to valid q (1 or 2)
//
// Ports:
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : request/response channel (ram_master_if.slave)
//   ram_addr : RAM word address
//   ram_data : RAM write data
//   ram_wren : RAM write enable (one cycle per accepted store)
//   ram_q    : RAM registered read data
//
// Build option:
//   RAM_MASTER_BOUNDS_CHECK_EN : when defined, requests with
//   req_addr >= DEPTH are rejected (no RAM access, rsp_err = 1,
//   rsp_rdata = 0). When undefined, rsp_err is tied to 0 and every
//   address is passed to the RAM unchanged.
// ---------------------------------------------------------------------------
module ram_master
    import ram_master_pkg::*;
#(
    parameter int DEPTH      = RAM_DEPTH_DEFAULT,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_master_if.slave           bus,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [RAM_DATA_W-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [RAM_DATA_W-1:0] ram_q
);

    // READ_WAIT lasts RD_LATENCY+1 cycles: one cycle for the RAM to capture
    // the address, then RD_LATENCY cycles until q is valid. The counter is
    // loaded with RD_LATENCY and the capture happens on the cycle it reads 0.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY);

    ram_master_state_t     state_reg;
    ram_master_state_t     state_next;
    logic [RAM_ADDR_W-1:0] addr_reg;
    logic [RAM_DATA_W-1:0] data_reg;
    logic [RAM_DATA_W-1:0] rdata_reg;
    logic                  we_reg;
    logic [1:0]            cnt_reg;

    logic                  accept;
    logic                  reject;
    logic                  cnt_done;

    assign accept   = bus.req_valid && (state_reg == IDLE);
    assign cnt_done = (cnt_reg == 2'd0);

`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    assign reject = accept && !addr_in_range(bus.req_addr, DEPTH);
`else
    assign reject = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_next = RESP;
                    end else if (bus.req_we) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                state_next = RESP;
            end
            READ_WAIT: begin
                if (cnt_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture, latency counter and read-data capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            data_reg  <= '0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= 2'd0;
        end else begin
            if (accept) begin
                // A rejected store must never strobe the RAM, so its write
                // flag is cleared here as well as skipping the WRITE state.
                we_reg    <= bus.req_we && !reject;
                cnt_reg   <= LAT_LOAD;
                rdata_reg <= '0;
                // Rejected requests leave the RAM pins untouched.
                if (!reject) begin
                    addr_reg <= bus.req_addr;
                    if (bus.req_we) begin
                        data_reg <= bus.req_wdata;
                    end
                end
            end else if (state_reg == READ_WAIT) begin
                if (cnt_done) begin
                    rdata_reg <= ram_q;
                end else begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
            end
        end
    end

`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= reject;
        end
    end

    assign bus.rsp_err = err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // ram_wren is decoded from the state register so that an asynchronous
    // reset drops it in the same instant the state returns to IDLE.
    assign ram_wren      = (state_reg == WRITE) && we_reg;
    assign ram_addr      = addr_reg;
    assign ram_data      = data_reg;

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rdata = rdata_reg;

endmodule : ram_master

// File: tb/tb_ram_master.sv
// ---------------------------------------------------------------------------
// tb_ram_master
// Self-checking bench for ram_master with a behavioural RamD attached.
// A transaction-level model (cycle offsets from acceptance, reference memory)
// checks the DUT outputs every cycle; directed steps pin the model with
// hand-computed literal expectations. Honours RAM_MASTER_BOUNDS_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_ram_master;
    import ram_master_pkg::*;

    localparam int DEPTH = RAM_DEPTH_DEFAULT;
    localparam int RDL   = 1;
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_master_if bus();

    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic [31:0] ram_q;
    logic        ram_wren;

    ram_master #(
        .DEPTH      (DEPTH),
        .RD_LATENCY (RDL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h111;
    endfunction

    // ---------------- behavioural RamD ----------------
    logic [31:0] ram_mem [DEPTH];
    logic [31:0] q1 = 32'h0;
    logic [31:0] q2 = 32'h0;
    bit          ram_init_done = 1'b0;

    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end else begin
            if (ram_wren && ram_addr < 32'(DEPTH)) ram_mem[ram_addr[8:0]] <= ram_data;
            q1 <= (ram_addr < 32'(DEPTH)) ? ram_mem[ram_addr[8:0]] : 32'h0;
            q2 <= q1;
        end
    end
    assign ram_q = (RDL == 1) ? q1 : q2;

    // ---------------- check helpers ----------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    rsp_t        rsp_q[$];
    int          acc_cyc_q[$];
    logic [31:0] ref_mem [DEPTH];
    bit          ref_init_done = 1'b0;
    bit          busy = 1'b0;
    int          k = 0;
    int          cyc = 0;
    int          wren_cnt = 0;
    bit          m_we, m_rej;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(negedge clk) begin
        int  resp_start;
        bit  exp_valid;
        if (!ref_init_done) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
            ref_init_done = 1'b1;
        end
        cyc++;
        if (ram_wren) wren_cnt++;
        if (!rst_n) begin
            chk1("rst_req_ready", bus.req_ready, 1'b1);
            chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk1("rst_ram_wren", ram_wren, 1'b0);
            chk32("rst_ram_addr", ram_addr, 32'h0);
            chk32("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
            chk1("rst_rsp_err", bus.rsp_err, 1'b0);
            busy = 1'b0;
        end else if (!busy) begin
            chk1("idle_req_ready", bus.req_ready, 1'b1);
            chk1("idle_rsp_valid", bus.rsp_valid, 1'b0);
            chk1("idle_ram_wren", ram_wren, 1'b0);
            if (bus.req_valid) begin
                m_we    = bus.req_we;
                m_addr  = bus.req_addr;
                m_wdata = bus.req_wdata;
                m_rej   = BOUNDS_EN && (bus.req_addr >= 32'(DEPTH));
                if (m_we || m_rej || m_addr >= 32'(DEPTH)) m_rdata = 32'h0;
                else m_rdata = ref_mem[m_addr[8:0]];
                if (m_we && !m_rej && m_addr < 32'(DEPTH)) ref_mem[m_addr[8:0]] = m_wdata;
                acc_cyc_q.push_back(cyc);
                busy = 1'b1;
                k = 1;
            end
        end else begin
            resp_start = m_rej ? 1 : (m_we ? 2 : 2 + RDL);
            exp_valid  = (k >= resp_start);
            chk1("busy_req_ready", bus.req_ready, 1'b0);
            chk1("rsp_valid", bus.rsp_valid, exp_valid);
            chk1("ram_wren", ram_wren, (k == 1) && m_we && !m_rej);
            if (!m_rej) chk32("ram_addr", ram_addr, m_addr);
            if ((k == 1) && m_we && !m_rej) chk32("ram_data", ram_data, m_wdata);
            if (exp_valid) begin
                chk32("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk1("rsp_err", bus.rsp_err, m_rej);
                if (bus.rsp_ready) begin
                    rsp_q.push_back('{bus.rsp_rdata, bus.rsp_err, k});
                    busy = 1'b0;
                end else begin
                    k++;
                end
            end else begin
                k++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a rising edge; drives in the same cycle.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit acc = 1'b0;
        int n = 0;
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            n++;
        end
        #1;
        bus.req_valid = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout: got no accept expected accept addr 0x%08h", addr);
        end
    endtask

    task automatic wait_rsp(output rsp_t r);
        int n = 0;
        while (rsp_q.size() == 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (rsp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_timeout: got no response expected one within 60 cycles");
            r = '{32'hxxxx_xxxx, 1'bx, -1};
        end else begin
            r = rsp_q.pop_front();
        end
    endtask

    function automatic int last_interval();
        int na = acc_cyc_q.size();
        if (na < 2) return -1;
        return acc_cyc_q[na-1] - acc_cyc_q[na-2];
    endfunction

    // ---------------- directed sequence ----------------
    logic [31:0] b2b_addr [3] = '{32'h0, 32'h9, 32'h11};
    logic [31:0] b2b_exp  [3] = '{32'hA000_0000, 32'hA000_0999, 32'hA000_1221};

    initial begin
        rsp_t r;
        int   w0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_req_ready", bus.req_ready, 1'b1);
        chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("reset_ram_wren", ram_wren, 1'b0);
        chk32("reset_ram_addr", ram_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);

        // Store 0x3 <- DEADBEEF then load 0x3
        w0 = wren_cnt;
        send(1'b1, 32'h3, 32'hDEAD_BEEF);
        wait_rsp(r);
        $display("[TB] store 0x3 data 0xdeadbeef -> rdata 0x%08h err %b lat %0d", r.rdata, r.err, r.lat);
        chk32("store_lat", 32'(r.lat), 32'd2);
        chk32("store_rdata", r.rdata, 32'h0);
        chk1("store_err", r.err, 1'b0);
        chk32("store_wren_cycles", 32'(wren_cnt - w0), 32'd1);
        send(1'b0, 32'h3, 32'h0);
        wait_rsp(r);
        $display("[TB] load 0x3 -> rdata 0x%08h err %b lat %0d", r.rdata, r.err, r.lat);
        chk32("load3_lat", 32'(r.lat), 32'd3);
        chk32("load3_rdata", r.rdata, 32'hDEAD_BEEF);
        chk32("store_to_load_interval", 32'(last_interval()), 32'd3);

        // Back-to-back loads, rsp_ready held high
        for (int i = 0; i < 3; i++) begin
            send(1'b0, b2b_addr[i], 32'h0);
            wait_rsp(r);
            $display("[TB] load 0x%08h -> rdata 0x%08h err %b lat %0d", b2b_addr[i], r.rdata, r.err, r.lat);
            chk32("b2b_rdata", r.rdata, b2b_exp[i]);
            if (i > 0) chk32("b2b_interval", 32'(last_interval()), 32'd4);
        end

        // Backpressure: rsp_ready low for 5 cycles of valid response
        #1;
        bus.rsp_ready = 1'b0;
        send(1'b0, 32'h9, 32'h0);
        repeat (7) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_rsp(r);
        $display("[TB] load 0x9 backpressured -> rdata 0x%08h err %b lat %0d", r.rdata, r.err, r.lat);
        chk32("bp_rdata", r.rdata, 32'hA000_0999);
        chk32("bp_lat", 32'(r.lat), 32'd8);

        // Out-of-range store
        w0 = wren_cnt;
        send(1'b1, 32'h148, 32'h1234_5678);
        wait_rsp(r);
        $display("[TB] store 0x148 -> rdata 0x%08h err %b lat %0d", r.rdata, r.err, r.lat);
`ifdef RAM_MASTER_BOUNDS_CHECK_EN
        chk1("oob_err", r.err, 1'b1);
        chk32("oob_lat", 32'(r.lat), 32'd1);
        chk32("oob_wren_cycles", 32'(wren_cnt - w0), 32'd0);
`else
        chk1("oob_err", r.err, 1'b0);
        chk32("oob_lat", 32'(r.lat), 32'd2);
        chk32("oob_wren_cycles", 32'(wren_cnt - w0), 32'd1);
`endif
        chk32("oob_rdata", r.rdata, 32'h0);

        // Reset during READ_WAIT of load 0x11
        send(1'b0, 32'h11, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk1("midrst_req_ready", bus.req_ready, 1'b1);
        chk1("midrst_ram_wren", ram_wren, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk32("midrst_no_rsp", 32'(rsp_q.size()), 32'd0);
        $display("[TB] load 0x11 aborted by reset");
        @(posedge clk);
        send(1'b0, 32'h0, 32'h0);
        wait_rsp(r);
        $display("[TB] load 0x0 after reset -> rdata 0x%08h err %b lat %0d", r.rdata, r.err, r.lat);
        chk32("post_rst_rdata", r.rdata, 32'hA000_0000);
        chk32("post_rst_lat", 32'(r.lat), 32'd3);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish before 100000 time units");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram_master
